// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier, one multiplier bit per clock, signed/unsigned per operation.
// Optional build macro MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] c
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               last_iter;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CW'(WIDTH-1)) || (mp[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CW'(WIDTH-1));
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
            c    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        mc  <= {{WIDTH{1'b0}}, mag_a};
                        mp  <= mag_b;
                        cnt <= '0;
                        neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    if (mp[0]) acc <= acc + mc;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    c    <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH=32): directed cases, handshake, async reset, random products.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] c;

    int checks = 0;
    int fails  = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .c(c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint px, py;
        if (s) begin
            px = longint'($signed(x));
            py = longint'($signed(y));
        end else begin
            px = longint'({32'b0, x});
            py = longint'({32'b0, y});
        end
        return 64'(px * py);
    endfunction

    // Number of edges from acceptance to the edge that raises done
    function automatic int ref_lat(input logic [31:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] m;
        int n;
        m = (s && y[31]) ? 32'(-y) : y;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 1;
`else
        return 33;
`endif
    endfunction

    // Entered at a negedge with the DUT idle (or in its done cycle); exits at the negedge of the done cycle.
    task automatic op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                      input bit mid_start, input string tag);
        int k;
        int busy_cnt;
        a = ta; b = tb; is_signed = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        k = 0;
        busy_cnt = 0;
        while (!done && k < 200) begin
            if (busy) busy_cnt++;
            if (mid_start && k == 5) begin
                start = 1'b1; a = 32'd2; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(k), 64'(ref_lat(tb, ts)));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ref_lat(tb, ts)));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_product"}, c, ref_prod(ta, tb, ts));
    endtask

    task automatic pulse_check(input string tag, input logic [63:0] cexp);
        @(negedge clk);
        chk({tag, "_done_single"}, 64'(done), 64'd0);
        chk({tag, "_c_hold"}, c, cexp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_c", c, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "umax");
        chk("umax_const", c, 64'hFFFFFFFE00000001);
        pulse_check("umax", 64'hFFFFFFFE00000001);
        op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, "sneg");
        chk("sneg_const", c, 64'hFFFFFFFFFFFFFFEB);
        op(32'h80000000, 32'h80000000, 1'b1, 1'b0, "smin");
        chk("smin_const", c, 64'h4000000000000000);
        op(32'hFFFFFFFB, 32'd0, 1'b1, 1'b0, "szero");
        op(32'h12345678, 32'd1, 1'b0, 1'b0, "uone");
        op(32'd3, 32'd5, 1'b0, 1'b0, "b5");
        op(32'd6, 32'd7, 1'b0, 1'b1, "ignore");
        chk("ignore_const", c, 64'd42);
        op(32'd9, 32'd9, 1'b0, 1'b0, "b2b");
        chk("b2b_const", c, 64'd81);
        pulse_check("b2b", 64'd81);

        // Asynchronous reset between edges in the middle of CALC
        op(32'd10, 32'd10, 1'b0, 1'b0, "pre_rst");
        a = 32'hDEADBEEF; b = 32'h12345678; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_c", c, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("arst_no_done", 64'(done), 64'd0);
        end
        op(32'd3, 32'd4, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
            case (i % 5)
                0: rb = rb >> $urandom_range(0, 31);
                1: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            op(ra, rb, rs, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
